// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands and holds each on A/B/sel for its programmed cycle count.
// Latency: a command accepted into an empty FIFO while idle is presented 2 cycles after acceptance.
// Backpressure: cmd_ready drops when the FIFO holds DEPTH entries; a same-cycle pop does not reopen it.
//
// Ports:
//   clk, reset (async, active-low)           clock and reset
//   cmd_valid/cmd_ready, cmd_a/b/sel/hold    command input handshake and payload
//   A, B, sel                                registered operands/op to the ALU
//   issue_valid, issue_start                 live-command flag and first-cycle pulse
//   busy, fifo_level, err_illegal            status; err_illegal is sticky until reset
//   flush (only with ALU_SEQ_FLUSH_EN)       synchronous, active-high queue/issue abort
//
// Build option: define ALU_SEQ_FLUSH_EN to add the flush input.

module alu_cmd_sequencer #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef ALU_SEQ_FLUSH_EN
    input  logic                      flush,
`endif
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_W-1:0]         cmd_a,
    input  logic [DATA_W-1:0]         cmd_b,
    input  logic [SEL_W-1:0]          cmd_sel,
    input  logic [HOLD_W-1:0]         cmd_hold,
    output logic [DATA_W-1:0]         A,
    output logic [DATA_W-1:0]         B,
    output logic [SEL_W-1:0]          sel,
    output logic                      issue_valid,
    output logic                      issue_start,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      err_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
        logic [HOLD_W-1:0] hold;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Flush source (tied off when the feature is not built)
    // ------------------------------------------------------------------
    logic flush_i;
`ifdef ALU_SEQ_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Input handshake
    // ------------------------------------------------------------------
    logic cmd_accept;
    logic cmd_illegal;
    logic fifo_push;
    cmd_t push_dat;

    // Ready depends on the stored count alone, so a pop in the same cycle
    // cannot reopen a full queue (keeps cmd_ready free of FSM paths).
    assign cmd_ready   = (fifo_level != LW'(DEPTH));
    assign cmd_accept  = cmd_valid && cmd_ready;
    assign cmd_illegal = (cmd_sel == {SEL_W{1'b1}});
    // Illegal ops are consumed from the bus but never stored; flush drops
    // any transfer landing in the same cycle.
    assign fifo_push   = cmd_accept && !cmd_illegal && !flush_i;

    assign push_dat.a    = cmd_a;
    assign push_dat.b    = cmd_b;
    assign push_dat.sel  = cmd_sel;
    assign push_dat.hold = cmd_hold;

    // ------------------------------------------------------------------
    // Command FIFO (circular buffer, power-of-two depth so pointers wrap)
    // ------------------------------------------------------------------
    cmd_t            fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   fifo_cnt;
    logic            fifo_pop;
    logic            fifo_empty;
    cmd_t            head;

    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];
    assign fifo_level = fifo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Storage has no reset; only entries below fifo_cnt are ever read.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= push_dat;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [HOLD_W-1:0] head_hold;

    // A hold of 0 is presented for one cycle like a hold of 1.
    assign head_hold = (head.hold == '0) ? HOLD_W'(1) : head.hold;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                // Pop uses the registered count, so a command pushed this
                // cycle cannot bypass the queue.
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_d    = HOLD;
                    hold_cnt_d = head_hold;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_W'(1)) begin
                    if (!fifo_empty) begin
                        // Back-to-back reload: next command appears with no bubble.
                        fifo_pop   = 1'b1;
                        hold_cnt_d = head_hold;
                    end else begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        if (flush_i) begin
            fifo_pop   = 1'b0;
            state_d    = IDLE;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // ALU-facing registers; A/B/sel keep their last values when idle
    // or flushed so the ALU input does not glitch.
    // ------------------------------------------------------------------
    logic start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A       <= '0;
            B       <= '0;
            sel     <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= fifo_pop;
            if (fifo_pop) begin
                A   <= head.a;
                B   <= head.b;
                sel <= head.sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_illegal <= 1'b0;
        end else if (cmd_accept && cmd_illegal) begin
            err_illegal <= 1'b1;
        end
    end

    assign issue_valid = (state_q == HOLD);
    assign issue_start = start_q;
    assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] cmd_hold;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] sel;
    logic       issue_valid;
    logic       issue_start;
    logic       busy;
    logic [2:0] fifo_level;
    logic       err_illegal;

    int vectors;
    int miscompares;

    alu_cmd_sequencer #(.DATA_W(8), .SEL_W(3), .DEPTH(DEPTH), .HOLD_W(4)) dut (
        .clk        (clk),
        .reset      (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
        .flush      (flush),
`endif
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .cmd_hold   (cmd_hold),
        .A          (A),
        .B          (B),
        .sel        (sel),
        .issue_valid(issue_valid),
        .issue_start(issue_start),
        .busy       (busy),
        .fifo_level (fifo_level),
        .err_illegal(err_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: a queue of pending commands plus the number of
    // cycles the current command still has on the ALU inputs.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [3:0] hold;
    } cmd_s;

    cmd_s       mq[$];
    int         m_rem;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [2:0] m_sel;
    logic       m_start;
    logic       m_err;

    task automatic model_reset();
        mq.delete();
        m_rem   = 0;
        m_a     = 8'h00;
        m_b     = 8'h00;
        m_sel   = 3'd0;
        m_start = 1'b0;
        m_err   = 1'b0;
    endtask

    // Applies the rules for one rising edge using the inputs as they stand.
    task automatic model_step();
        int   sz;
        bit   acc;
        bit   legal;
        cmd_s c;
        sz    = mq.size();
        acc   = cmd_valid && (sz != DEPTH);
        legal = (cmd_sel != 3'b111);
        if (acc && !legal) m_err = 1'b1;
        if (flush) begin
            mq.delete();
            m_rem   = 0;
            m_start = 1'b0;
        end else begin
            if (m_rem > 0) m_rem = m_rem - 1;
            m_start = 1'b0;
            if (m_rem == 0 && sz > 0) begin
                c       = mq.pop_front();
                m_a     = c.a;
                m_b     = c.b;
                m_sel   = c.sel;
                m_rem   = (c.hold == 0) ? 1 : int'(c.hold);
                m_start = 1'b1;
            end
            if (acc && legal) begin
                c.a = cmd_a; c.b = cmd_b; c.sel = cmd_sel; c.hold = cmd_hold;
                mq.push_back(c);
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] s, input logic [3:0] h);
        int n;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s; cmd_hold = h;
        n = 0;
        while (!cmd_ready && n < 40) begin
            cyc();
            n++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!issue_start && n < 20) begin
            cyc();
            n++;
        end
        vectors++;
        if (!issue_start) begin
            miscompares++;
            $display("FAIL %s_start_timeout: issue_start=%b, required 1", tag, issue_start);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({A, B, sel} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_abs: got %h/%h/%h required 0/0/0", A, B, sel);
        end
        vectors++;
        if ({issue_valid, issue_start, err_illegal, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got v%b s%b e%b b%b required all 0",
                     issue_valid, issue_start, err_illegal, busy);
        end
        vectors++;
        if (fifo_level !== 3'd0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_level: got lvl=%0d rdy=%b required 0/1", fifo_level, cmd_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        push_cmd(8'h05, 8'h03, 3'b000, 4'd1);
        vectors++;
        if (issue_valid !== 1'b0 || fifo_level !== 3'd1) begin
            miscompares++;
            $display("FAIL single_accept: got v=%b lvl=%0d required 0/1", issue_valid, fifo_level);
        end
        cyc();
        vectors++;
        if ({issue_valid, issue_start, A, B, sel} !== {1'b1, 1'b1, 8'h05, 8'h03, 3'b000}) begin
            miscompares++;
            $display("FAIL single_issue: got v%b s%b %h/%h/%h required v1 s1 05/03/0",
                     issue_valid, issue_start, A, B, sel);
        end
        cyc();
        vectors++;
        if (issue_valid !== 1'b0 || busy !== 1'b0 || issue_start !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle: got v=%b b=%b s=%b required 0/0/0", issue_valid, busy, issue_start);
        end
    endtask

    task automatic test_hold();
        push_cmd(8'h05, 8'h03, 3'b011, 4'd5);
        push_cmd(8'h05, 8'h03, 3'b100, 4'd0);
        wait_start("hold");
        for (int i = 0; i < 7; i++) begin
            logic       ev;
            logic       es;
            logic [2:0] esel;
            ev   = (i < 6);
            es   = (i == 0) || (i == 5);
            esel = (i < 5) ? 3'b011 : 3'b100;
            vectors++;
            if (issue_valid !== ev || issue_start !== es || (ev && sel !== esel)) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got v%b s%b sel=%0d required v%b s%b sel=%0d",
                         i, issue_valid, issue_start, sel, ev, es, esel);
            end
            cyc();
        end
    endtask

    task automatic test_full();
        int         n;
        logic [7:0] exp_a;
        push_cmd(8'h10, 8'h00, 3'b000, 4'd15);
        wait_start("full");
        for (int k = 1; k <= 4; k++) push_cmd(8'(8'h10 + k), 8'h00, 3'b101, 4'd1);
        vectors++;
        if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_level: got lvl=%0d rdy=%b required 4/0", fifo_level, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_a = 8'h15; cmd_b = 8'h00; cmd_sel = 3'b110; cmd_hold = 4'd1;
        n = 0;
        while (!cmd_ready && n < 40) begin
            cyc();
            n++;
        end
        vectors++;
        if (issue_start !== 1'b1 || A !== 8'h11 || fifo_level !== 3'd3) begin
            miscompares++;
            $display("FAIL full_reopen: got s=%b A=%h lvl=%0d required 1/11/3", issue_start, A, fifo_level);
        end
        cyc();
        cmd_valid = 1'b0;
        exp_a = 8'h12;
        for (int i = 0; i < 20; i++) begin
            if (issue_start) begin
                vectors++;
                if (A !== exp_a) begin
                    miscompares++;
                    $display("FAIL full_order: got A=%h required %h", A, exp_a);
                end
                exp_a = exp_a + 8'h01;
            end
            cyc();
        end
        vectors++;
        if (exp_a !== 8'h16 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_count: got next=%h busy=%b required 16/0", exp_a, busy);
        end
    endtask

    task automatic test_illegal();
        cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_sel = 3'b111; cmd_hold = 4'd3;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_ready: got %b required 1", cmd_ready);
        end
        cyc();
        cmd_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd0 || err_illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_flag: got lvl=%0d err=%b required 0/1", fifo_level, err_illegal);
        end
        cyc();
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_noissue: got v=%b required 0", issue_valid);
        end
        push_cmd(8'h01, 8'h02, 3'b110, 4'd2);
        for (int i = 0; i < 5; i++) cyc();
        vectors++;
        if (err_illegal !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_sticky: got err=%b busy=%b required 1/0", err_illegal, busy);
        end
    endtask

    task automatic test_reset_mid();
        push_cmd(8'h21, 8'h22, 3'b010, 4'd8);
        wait_start("rstmid");
        push_cmd(8'h31, 8'h32, 3'b000, 4'd2);
        push_cmd(8'h41, 8'h42, 3'b001, 4'd2);
        vectors++;
        if (issue_valid !== 1'b1 || fifo_level !== 3'd2) begin
            miscompares++;
            $display("FAIL rstmid_pre: got v=%b lvl=%0d required 1/2", issue_valid, fifo_level);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({A, B, sel, issue_valid, issue_start, err_illegal, fifo_level, busy} !== 26'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h/%h/%h v%b s%b e%b lvl=%0d b%b required all 0",
                     A, B, sel, issue_valid, issue_start, err_illegal, fifo_level, busy);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (issue_valid !== 1'b0 || fifo_level !== 3'd0) begin
                miscompares++;
                $display("FAIL rstmid_after%0d: got v=%b lvl=%0d required 0/0", i, issue_valid, fifo_level);
            end
        end
    endtask

`ifdef ALU_SEQ_FLUSH_EN
    task automatic test_flush();
        push_cmd(8'h51, 8'h52, 3'b000, 4'd10);
        wait_start("flush");
        for (int k = 0; k < 3; k++) push_cmd(8'(8'h60 + k), 8'h00, 3'b100, 4'd1);
        flush = 1'b1;
        cmd_valid = 1'b1; cmd_a = 8'h70; cmd_b = 8'h71; cmd_sel = 3'b101; cmd_hold = 4'd1;
        cyc();
        flush = 1'b0;
        cmd_valid = 1'b0;
        vectors++;
        if (issue_valid !== 1'b0 || fifo_level !== 3'd0 || cmd_ready !== 1'b1 || issue_start !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_state: got v=%b lvl=%0d rdy=%b s=%b required 0/0/1/0",
                     issue_valid, fifo_level, cmd_ready, issue_start);
        end
        cyc();
        vectors++;
        if (issue_valid !== 1'b0 || A !== 8'h51) begin
            miscompares++;
            $display("FAIL flush_after: got v=%b A=%h required 0/51", issue_valid, A);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 420; i++) begin
            if (i < 300) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_a     = 8'($urandom);
                cmd_b     = 8'($urandom);
                cmd_sel   = 3'($urandom_range(0, 7));
                cmd_hold  = 4'($urandom_range(0, 4));
            end else begin
                cmd_valid = 1'b0;
            end
            cyc();
            vectors++;
            if (issue_valid !== (m_rem > 0) || issue_start !== m_start) begin
                miscompares++;
                $display("FAIL rand_issue cyc%0d: got v%b s%b required v%b s%b",
                         i, issue_valid, issue_start, (m_rem > 0), m_start);
            end
            vectors++;
            if (A !== m_a || B !== m_b || sel !== m_sel) begin
                miscompares++;
                $display("FAIL rand_abs cyc%0d: got %h/%h/%h required %h/%h/%h",
                         i, A, B, sel, m_a, m_b, m_sel);
            end
            vectors++;
            if (fifo_level !== 3'(mq.size()) || cmd_ready !== (mq.size() != DEPTH)) begin
                miscompares++;
                $display("FAIL rand_level cyc%0d: got lvl=%0d rdy=%b required %0d/%b",
                         i, fifo_level, cmd_ready, mq.size(), (mq.size() != DEPTH));
            end
            vectors++;
            if (busy !== (mq.size() > 0 || m_rem > 0) || err_illegal !== m_err) begin
                miscompares++;
                $display("FAIL rand_status cyc%0d: got b=%b e=%b required %b/%b",
                         i, busy, err_illegal, (mq.size() > 0 || m_rem > 0), m_err);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain: got busy=%b required 0", busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        flush       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = 8'h00;
        cmd_b       = 8'h00;
        cmd_sel     = 3'd0;
        cmd_hold    = 4'd0;
        model_reset();
        test_reset();
        test_single();
        test_hold();
        test_full();
        test_illegal();
        test_reset_mid();
`ifdef ALU_SEQ_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream feeder for the 8-bit ALU: accepts operation commands (A, B, sel, hold count) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's A, B and sel inputs, holding each command stable for its programmed number of cycles, e.g. multi-cycle hold for the counter op (sel 011).
- Lets a testbench or controller queue ALU work without cycle-exact timing.

Parameters:
- DATA_W, 8, width of A/B operands.
- SEL_W, 3, width of ALU op select.
- DEPTH, 4, command FIFO entries (power of two, >=2).
- HOLD_W, 4, width of per-command hold count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; a transfer occurs when cmd_valid && cmd_ready at a rising edge.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_sel  in  SEL_W  ALU op: 000 add, 001 shl, 010 shr, 011 counter, 100 and, 101 or, 110 xor, 111 illegal.
- cmd_hold  in  HOLD_W  cycles to present the command; 0 is treated as 1.
- A  out  DATA_W  to ALU A.
- B  out  DATA_W  to ALU B.
- sel  out  SEL_W  to ALU sel.
- issue_valid  out  1  A/B/sel carry a live command this cycle.
- issue_start  out  1  one-cycle pulse on the first cycle of each issued command.
- busy  out  1  FIFO non-empty or state != IDLE.
- fifo_level  out  clog2(DEPTH)+1  entries stored.
- err_illegal  out  1  sticky: a sel=111 command was offered.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, state=IDLE.
  - A, B, sel, issue_valid, issue_start, err_illegal, fifo_level all 0.
  - Outputs respond immediately, without waiting for a clock edge.
  - Reset mid-hold aborts the current command and discards all queued commands.
- Input side:
  - cmd_ready = (fifo_level != DEPTH), derived combinationally from the count only.
  - A pop in the same cycle does not raise cmd_ready when full.
  - sel=111 with cmd_valid && cmd_ready is consumed but not written; err_illegal sets and stays set until reset.
- FSM has two states: IDLE and HOLD.
- IDLE:
  - FIFO empty: issue_valid=0; A/B/sel keep their last values.
  - FIFO non-empty at a rising edge: pop the head; register A/B/sel; load hold_cnt = max(cmd_hold,1); set issue_valid=1 and issue_start=1; go to HOLD.
- HOLD:
  - issue_valid=1; issue_start=0 after the first cycle; hold_cnt decrements each edge.
  - At an edge with hold_cnt==1 and FIFO non-empty: pop the next command back-to-back (no bubble), reload, pulse issue_start.
  - At an edge with hold_cnt==1 and FIFO empty: go to IDLE, issue_valid=0.
- Latency: a command accepted into an empty FIFO while IDLE at edge N produces issue_valid=1 and issue_start=1 after edge N+1, i.e. 2 cycles from accept to issue.
- No bypass: pop is impossible when the FIFO is empty, even if a push occurs the same cycle.
- Simultaneous push and pop: fifo_level unchanged; pointers wrap modulo DEPTH.
- A command with cmd_hold=h occupies exactly h cycles of issue_valid (h=0 gives 1 cycle).

Optional Feature:
- Macro: ALU_SEQ_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, synchronous, active-high).
  - At a rising edge with flush=1: FIFO emptied, state=IDLE, issue_valid=0, issue_start=0; A/B/sel keep last values; err_illegal unaffected.
  - A cmd transfer in the same cycle as flush is discarded; flush has priority.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
1. Reset release, then push {A=05, B=03, sel=000, hold=1} -> 2 cycles later A=05, B=03, sel=000, issue_valid=1, issue_start=1 for 1 cycle; then issue_valid=0, busy=0.
2. Push {05, 03, sel=011, hold=5} then {05, 03, sel=100, hold=0} -> sel=011 for exactly 5 cycles, then sel=100 on the very next cycle with a second issue_start pulse, then idle.
3. Hold the first command at hold=15, push 5 more -> cmd_ready drops when fifo_level=4; the 5th push is accepted only after the first pop; no command lost or duplicated, order preserved.
4. Push {sel=111} -> cmd_ready=1, fifo_level stays 0, err_illegal=1 and remains 1 through later legal commands until reset.
5. Assert reset=0 mid-way through a hold=8 command with 2 queued -> outputs and fifo_level are 0 before the next clock edge; after release, nothing issues.
6. (ALU_SEQ_FLUSH_EN) Flush while issuing with 3 queued plus a concurrent push -> next cycle issue_valid=0, fifo_level=0, cmd_ready=1.
